// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search controller.
// This block drives operand `a` (probe) of a magnitude comparator. The
// unknown target sits on operand `b`. The block binary-searches the target
// using the comparator's greater/lesser/equal flags.
// CMP_LAT sets the comparator pipeline latency in clocks (0 = combinational).
// Optional feature macro: SAR_STEP_COUNT_EN adds the `steps` output, which
// counts the comparisons made by the last search.
module sar_search_ctrl #(
    parameter int N       = 8,
    parameter int CMP_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     a_greater,
    input  logic                     a_lesser,
    input  logic                     equal,
    output logic [N-1:0]             probe,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic                     error,
`ifdef SAR_STEP_COUNT_EN
    output logic [$clog2(N+2)-1:0]   steps,
`endif
    output logic [N-1:0]             result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [N-1:0] ZERO_V     = {N{1'b0}};
    localparam logic [N-1:0] ONE_V      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MAX_V      = {N{1'b1}};
    localparam logic [N-1:0] INIT_PROBE = {1'b0, {(N-1){1'b1}}};
    localparam logic [2:0]   WAIT_LAST  = 3'(CMP_LAT - 1);
    // After a bound update, go back through WAIT only when the comparator is pipelined.
    localparam state_t       LOOP_ST    = (CMP_LAT > 0) ? ST_WAIT : ST_EVAL;

    // The sum is taken at N+1 bits, so the midpoint cannot overflow.
    function automatic logic [N-1:0] mid_f(input logic [N-1:0] lo, input logic [N-1:0] hi);
        logic [N:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return sum[N:1];
    endfunction

    state_t       state_r, state_s;
    logic [N-1:0] low_r, low_s, high_r, high_s, probe_r, probe_s, result_r, result_s;
    logic [2:0]   wait_cnt_r, wait_cnt_s;
    logic         busy_r, busy_s, done_r, done_s, found_r, found_s, error_r, error_s;
`ifdef SAR_STEP_COUNT_EN
    logic [$clog2(N+2)-1:0] steps_r, steps_s;
`endif

    // Next-state logic and next values of all registers.
    always_comb begin
        state_s    = state_r;
        low_s      = low_r;
        high_s     = high_r;
        probe_s    = probe_r;
        wait_cnt_s = wait_cnt_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        found_s    = found_r;
        error_s    = error_r;
        result_s   = result_r;
`ifdef SAR_STEP_COUNT_EN
        steps_s    = steps_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    low_s      = ZERO_V;
                    high_s     = MAX_V;
                    probe_s    = INIT_PROBE;
                    wait_cnt_s = 3'd0;
                    busy_s     = 1'b1;
                    found_s    = 1'b0;
                    error_s    = 1'b0;
                    result_s   = ZERO_V;
`ifdef SAR_STEP_COUNT_EN
                    steps_s    = '0;
`endif
                    state_s    = LOOP_ST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s = ST_EVAL;
                end else begin
                    wait_cnt_s = wait_cnt_r + 3'd1;
                end
            end
            ST_EVAL: begin
`ifdef SAR_STEP_COUNT_EN
                steps_s = steps_r + 1'b1;
`endif
                wait_cnt_s = 3'd0;
                case ({a_greater, a_lesser, equal})
                    3'b001: begin
                        found_s  = 1'b1;
                        result_s = probe_r;
                        state_s  = ST_DONE;
                    end
                    3'b100: begin
                        if (probe_r == low_r) begin
                            error_s = 1'b1;
                            state_s = ST_DONE;
                        end else begin
                            high_s  = probe_r - ONE_V;
                            probe_s = mid_f(low_r, probe_r - ONE_V);
                            state_s = LOOP_ST;
                        end
                    end
                    3'b010: begin
                        if (probe_r == high_r) begin
                            error_s = 1'b1;
                            state_s = ST_DONE;
                        end else begin
                            low_s   = probe_r + ONE_V;
                            probe_s = mid_f(probe_r + ONE_V, high_r);
                            state_s = LOOP_ST;
                        end
                    end
                    default: begin
                        error_s = 1'b1;
                        state_s = ST_DONE;
                    end
                endcase
            end
            ST_DONE: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            low_r      <= ZERO_V;
            high_r     <= MAX_V;
            probe_r    <= ZERO_V;
            wait_cnt_r <= 3'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            found_r    <= 1'b0;
            error_r    <= 1'b0;
            result_r   <= ZERO_V;
`ifdef SAR_STEP_COUNT_EN
            steps_r    <= '0;
`endif
        end else begin
            state_r    <= state_s;
            low_r      <= low_s;
            high_r     <= high_s;
            probe_r    <= probe_s;
            wait_cnt_r <= wait_cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            found_r    <= found_s;
            error_r    <= error_s;
            result_r   <= result_s;
`ifdef SAR_STEP_COUNT_EN
            steps_r    <= steps_s;
`endif
        end
    end

    assign probe  = probe_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign found  = found_r;
    assign error  = error_r;
    assign result = result_r;
`ifdef SAR_STEP_COUNT_EN
    assign steps  = steps_r;
`endif

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Testbench for sar_search_ctrl. There are two instances: one has a 1-cycle
// registered comparator and the other a combinational comparator. Expected
// probe sequences are queued when a search starts. Each new probe the DUT
// drives is popped from the queue and checked.
module tb_sar_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] target = 8'd0;
    int         mode = 0;   // 0: true comparator, 1: greater+lesser, 2: always greater
    int         sel = 1;
    int         cyc = 0;

    logic [7:0] probe0, probe1, result0, result1, p1_d;
    logic       busy0, done0, found0, error0, busy1, done1, found1, error1;
    logic       ag0, al0, eq0, ag1, al1, eq1;
`ifdef SAR_STEP_COUNT_EN
    logic [3:0] steps0, steps1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator with 1-cycle delay for dut1, combinational for dut0
    always @(posedge clk) p1_d <= probe1;
    assign ag1 = (mode != 0) ? 1'b1 : (p1_d > target);
    assign al1 = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (p1_d < target);
    assign eq1 = (mode == 0) && (p1_d == target);
    assign ag0 = probe0 > target;
    assign al0 = probe0 < target;
    assign eq0 = probe0 == target;

    sar_search_ctrl #(.N(8), .CMP_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a_greater(ag0), .a_lesser(al0), .equal(eq0),
        .probe(probe0), .busy(busy0), .done(done0), .found(found0), .error(error0),
`ifdef SAR_STEP_COUNT_EN
        .steps(steps0),
`endif
        .result(result0));

    sar_search_ctrl #(.N(8), .CMP_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_greater(ag1), .a_lesser(al1), .equal(eq1),
        .probe(probe1), .busy(busy1), .done(done1), .found(found1), .error(error1),
`ifdef SAR_STEP_COUNT_EN
        .steps(steps1),
`endif
        .result(result1));

    logic [7:0] m_probe, m_result;
    logic       m_busy, m_done, m_found, m_error;
    assign m_probe  = (sel == 1) ? probe1  : probe0;
    assign m_result = (sel == 1) ? result1 : result0;
    assign m_busy   = (sel == 1) ? busy1   : busy0;
    assign m_done   = (sel == 1) ? done1   : done0;
    assign m_found  = (sel == 1) ? found1  : found0;
    assign m_error  = (sel == 1) ? error1  : error0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_probe(input string tag);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD;
        chk({tag, " probe"}, {24'd0, m_probe}, e);
    endtask

    task automatic push_seq(input int n, input logic [7:0] v [16]);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    task automatic run_search(input string tag, input int s, input int tgt, input int md,
                              input logic exp_found, input int exp_res, input logic exp_err,
                              input int exp_done_k, input int exp_cmp, input int pulse_k);
        int k;
        int n_cmp;
        bit got_done;
        logic [7:0] last;
        sel = s; target = tgt[7:0]; mode = md;
        @(negedge clk);
        if (s == 1) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        k = 0;
        chk({tag, " busy"}, {31'd0, m_busy}, 32'd1);
        chk_probe(tag);
        n_cmp = 1;
        last = m_probe;
        got_done = 1'b0;
        while (!got_done && k < 200) begin
            if (k == pulse_k) begin
                if (s == 1) start1 = 1'b1; else start0 = 1'b1;
            end
            @(negedge clk);
            k++;
            start0 = 1'b0; start1 = 1'b0;
            if (m_done) begin
                got_done = 1'b1;
            end else if (m_probe !== last) begin
                chk_probe(tag);
                n_cmp++;
                last = m_probe;
            end
        end
        chk({tag, " done seen"}, {31'd0, got_done}, 32'd1);
        chk({tag, " done cycle"}, k, exp_done_k);
        chk({tag, " found"}, {31'd0, m_found}, {31'd0, exp_found});
        chk({tag, " result"}, {24'd0, m_result}, exp_res);
        chk({tag, " error"}, {31'd0, m_error}, {31'd0, exp_err});
        chk({tag, " busy low"}, {31'd0, m_busy}, 32'd0);
        chk({tag, " comparisons"}, n_cmp, exp_cmp);
        chk({tag, " queue left"}, exp_q.size(), 32'd0);
`ifdef SAR_STEP_COUNT_EN
        chk({tag, " steps"}, (s == 1) ? {28'd0, steps1} : {28'd0, steps0}, exp_cmp);
`endif
        @(negedge clk);
        chk({tag, " done width"}, {31'd0, m_done}, 32'd0);
        repeat (4) @(negedge clk);
        chk({tag, " idle after"}, {31'd0, m_busy}, 32'd0);
        chk({tag, " probe held"}, {24'd0, m_probe}, {24'd0, last});
    endtask

    logic [7:0] seq_100 [16] = '{8'd127, 8'd63, 8'd95, 8'd111, 8'd103, 8'd99, 8'd101, 8'd100,
                                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] seq_255 [16] = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254,
                                 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] seq_dn [16]  = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0,
                                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] seq_one [16] = '{8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    initial begin
        // Reset state of both instances
        repeat (2) @(negedge clk);
        #1;
        chk("rst probe1", {24'd0, probe1}, 32'd0);
        chk("rst flags1", {28'd0, busy1, done1, found1, error1}, 32'd0);
        chk("rst result1", {24'd0, result1}, 32'd0);
        chk("rst probe0", {24'd0, probe0}, 32'd0);
        chk("rst flags0", {28'd0, busy0, done0, found0, error0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push_seq(8, seq_100);
        run_search("lat1_t100", 1, 100, 0, 1'b1, 100, 1'b0, 17, 8, -1);
        push_seq(9, seq_255);
        run_search("lat0_t255", 0, 255, 0, 1'b1, 255, 1'b0, 10, 9, -1);
        push_seq(8, seq_dn);
        run_search("lat0_t0", 0, 0, 0, 1'b1, 0, 1'b0, 9, 8, -1);
        push_seq(1, seq_one);
        run_search("bothflags", 1, 100, 1, 1'b0, 0, 1'b1, 3, 1, -1);
        push_seq(8, seq_dn);
        run_search("always_gt", 1, 100, 2, 1'b0, 0, 1'b1, 17, 8, -1);

        // Reset during the third WAIT of a search
        sel = 1; target = 8'd100; mode = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        chk("midrst p0", {24'd0, probe1}, 32'd127);
        repeat (4) @(negedge clk);
        chk("midrst p2", {24'd0, probe1}, 32'd95);
        rst_n = 1'b0;
        #1;
        chk("midrst probe", {24'd0, probe1}, 32'd0);
        chk("midrst flags", {28'd0, busy1, done1, found1, error1}, 32'd0);
        chk("midrst result", {24'd0, result1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst no done", {31'd0, done1}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst idle", {31'd0, busy1}, 32'd0);

        push_seq(8, seq_100);
        run_search("postrst_t100", 1, 100, 0, 1'b1, 100, 1'b0, 17, 8, -1);
        push_seq(8, seq_100);
        run_search("busy_start", 1, 100, 0, 1'b1, 100, 1'b0, 17, 8, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
